// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver/host side and the uart_rx_fifo receive buffer.
// ERR_COUNT exists only when UART_RX_FIFO_DROP_ERR_EN is defined.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  WR_VALID;
    logic                  WR_PAR_ERR;
    logic                  WR_FRM_ERR;
    logic                  RD_EN;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  RD_PAR_ERR;
    logic                  RD_FRM_ERR;
    logic                  RD_VALID;
    logic                  EMPTY;
    logic                  FULL;
    logic [ADDR_WIDTH:0]   LEVEL;
    logic                  OVERRUN;
    logic                  OVR_CLR;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic [7:0]            ERR_COUNT;

    modport master (
        output WR_DATA, WR_VALID, WR_PAR_ERR, WR_FRM_ERR, RD_EN, OVR_CLR,
        input  RD_DATA, RD_PAR_ERR, RD_FRM_ERR, RD_VALID, EMPTY, FULL, LEVEL, OVERRUN,
               ERR_COUNT
    );

    modport slave (
        input  WR_DATA, WR_VALID, WR_PAR_ERR, WR_FRM_ERR, RD_EN, OVR_CLR,
        output RD_DATA, RD_PAR_ERR, RD_FRM_ERR, RD_VALID, EMPTY, FULL, LEVEL, OVERRUN,
               ERR_COUNT
    );
`else
    modport master (
        output WR_DATA, WR_VALID, WR_PAR_ERR, WR_FRM_ERR, RD_EN, OVR_CLR,
        input  RD_DATA, RD_PAR_ERR, RD_FRM_ERR, RD_VALID, EMPTY, FULL, LEVEL, OVERRUN
    );

    modport slave (
        input  WR_DATA, WR_VALID, WR_PAR_ERR, WR_FRM_ERR, RD_EN, OVR_CLR,
        output RD_DATA, RD_PAR_ERR, RD_FRM_ERR, RD_VALID, EMPTY, FULL, LEVEL, OVERRUN
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO behind the UART receiver with registered read port and sticky overrun.
// Optional UART_RX_FIFO_DROP_ERR_EN: drop errored frames and count them in ERR_COUNT.
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input logic           RX_CLK,
    input logic           RST,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = 8;

    // Errored frames never reach the memory when dropping is enabled, so flags are not stored
    typedef struct packed {
`ifndef UART_RX_FIFO_DROP_ERR_EN
        logic                  frm;
        logic                  par;
`endif
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                mem_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overrun_q, overrun_d;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic                  err_frame_c;
`else
    logic                  rd_par_q, rd_par_d;
    logic                  rd_frm_q, rd_frm_d;
`endif

    logic                  empty_c;
    logic                  full_c;
    logic [PTR_W-1:0]      level_c;
    logic                  rd_en_c;
    logic                  wr_en_c;
    logic                  drop_c;
    entry_t                wr_entry_c;
    entry_t                rd_entry_c;

    // Status, handshake qualification and next-state for all registers
    always_comb begin
        empty_c    = 1'b0;
        full_c     = 1'b0;
        level_c    = '0;
        rd_en_c    = 1'b0;
        wr_en_c    = 1'b0;
        drop_c     = 1'b0;
        wr_entry_c = '0;
        rd_entry_c = '0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overrun_d  = overrun_q;
`ifdef UART_RX_FIFO_DROP_ERR_EN
        err_cnt_d   = err_cnt_q;
        err_frame_c = 1'b0;
`else
        rd_par_d    = rd_par_q;
        rd_frm_d    = rd_frm_q;
`endif

        empty_c = (wr_ptr_q == rd_ptr_q);
        full_c  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0])
               && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        level_c = wr_ptr_q - rd_ptr_q;

        wr_entry_c.data = bus.WR_DATA;
`ifdef UART_RX_FIFO_DROP_ERR_EN
        err_frame_c = bus.WR_VALID && (bus.WR_PAR_ERR || bus.WR_FRM_ERR);
        rd_en_c     = bus.RD_EN && !empty_c;
        wr_en_c     = bus.WR_VALID && !err_frame_c && (!full_c || bus.RD_EN);
        drop_c      = bus.WR_VALID && !err_frame_c && full_c && !bus.RD_EN;
        if (err_frame_c && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
`else
        wr_entry_c.par = bus.WR_PAR_ERR;
        wr_entry_c.frm = bus.WR_FRM_ERR;
        rd_en_c        = bus.RD_EN && !empty_c;
        wr_en_c        = bus.WR_VALID && (!full_c || bus.RD_EN);
        drop_c         = bus.WR_VALID && full_c && !bus.RD_EN;
`endif

        rd_entry_c = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (rd_en_c) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rd_data_d  = rd_entry_c.data;
            rd_valid_d = 1'b1;
`ifndef UART_RX_FIFO_DROP_ERR_EN
            rd_par_d   = rd_entry_c.par;
            rd_frm_d   = rd_entry_c.frm;
`endif
        end

        // A dropped frame wins over a same-cycle clear
        if (drop_c) begin
            overrun_d = 1'b1;
        end else if (bus.OVR_CLR) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (!RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_FIFO_DROP_ERR_EN
            err_cnt_q  <= '0;
`else
            rd_par_q   <= 1'b0;
            rd_frm_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_FIFO_DROP_ERR_EN
            err_cnt_q  <= err_cnt_d;
`else
            rd_par_q   <= rd_par_d;
            rd_frm_q   <= rd_frm_d;
`endif
        end
    end

    // Storage is not reset; the pointers alone define which entries are live
    always_ff @(posedge RX_CLK) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_entry_c;
        end
    end

    assign bus.RD_DATA    = rd_data_q;
    assign bus.RD_VALID   = rd_valid_q;
    assign bus.EMPTY      = empty_c;
    assign bus.FULL       = full_c;
    assign bus.LEVEL      = level_c;
    assign bus.OVERRUN    = overrun_q;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign bus.RD_PAR_ERR = 1'b0;
    assign bus.RD_FRM_ERR = 1'b0;
    assign bus.ERR_COUNT  = err_cnt_q;
`else
    assign bus.RD_PAR_ERR = rd_par_q;
    assign bus.RD_FRM_ERR = rd_frm_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table plus multi-cycle corner sequences.
module tb_uart_rx_fifo;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .RX_CLK (clk),
        .RST    (rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference queue model and expected registered outputs
    logic [9:0] mq [$];
    logic       m_ovr;
    logic       m_rv;
    logic [7:0] m_rd;
    logic       m_pe;
    logic       m_fe;
    int         m_err;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       pe;
        logic       re;
        logic       e_rv;
        logic [7:0] e_rd;
        logic       e_pe;
        logic       e_empty;
        logic [4:0] e_lvl;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, then advance the model
    task automatic cycle(input logic wv, input logic [7:0] wd, input logic pe, input logic fe,
                         input logic re, input logic oc, input logic rs);
        bit         full_m;
        bit         empty_m;
        bit         err_f;
        bit         set_o;
        logic [9:0] e;
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0);
        bus.WR_VALID   = wv;
        bus.WR_DATA    = wd;
        bus.WR_PAR_ERR = pe;
        bus.WR_FRM_ERR = fe;
        bus.RD_EN      = re;
        bus.OVR_CLR    = oc;
        rst            = rs;
        @(posedge clk);
        #1;
        if (!rs) begin
            mq.delete();
            m_ovr = 1'b0;
            m_rv  = 1'b0;
            m_rd  = 8'h00;
            m_pe  = 1'b0;
            m_fe  = 1'b0;
            m_err = 0;
        end else begin
            err_f = 1'b0;
`ifdef UART_RX_FIFO_DROP_ERR_EN
            err_f = wv && (pe || fe);
`endif
            m_rv = re && !empty_m;
            if (m_rv) begin
                e    = mq.pop_front();
                m_rd = e[7:0];
                m_pe = e[8];
                m_fe = e[9];
            end
            set_o = 1'b0;
            if (wv && !err_f) begin
                if (!full_m || re) mq.push_back({fe, pe, wd});
                else set_o = 1'b1;
            end
            if (set_o) m_ovr = 1'b1;
            else if (oc) m_ovr = 1'b0;
            if (err_f && m_err < 255) m_err++;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rd();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " rd_valid"}, 32'(bus.RD_VALID), 32'(m_rv));
        chk({tag, " rd_data"},  32'(bus.RD_DATA), 32'(m_rd));
        chk({tag, " rd_par"},   32'(bus.RD_PAR_ERR), 32'(m_pe));
        chk({tag, " rd_frm"},   32'(bus.RD_FRM_ERR), 32'(m_fe));
        chk({tag, " empty"},    32'(bus.EMPTY), 32'(mq.size() == 0));
        chk({tag, " full"},     32'(bus.FULL), 32'(mq.size() == DEPTH));
        chk({tag, " level"},    32'(bus.LEVEL), 32'(mq.size()));
        chk({tag, " overrun"},  32'(bus.OVERRUN), 32'(m_ovr));
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk({tag, " err_count"}, 32'(bus.ERR_COUNT), 32'(m_err));
`endif
    endtask

    initial begin
        // {wv, wd, pe, re, e_rv, e_rd, e_pe, e_empty, e_lvl}
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd2};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd3};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 5'd2};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 5'd1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 5'd0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 5'd0};
`ifdef UART_RX_FIFO_DROP_ERR_EN
        tbl[7] = '{1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 5'd0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 5'd0};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 5'd0};
`else
        tbl[7] = '{1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 5'd1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 5'd0};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b1, 5'd0};
`endif

        bus.WR_VALID = 1'b0; bus.WR_DATA = 8'h00; bus.WR_PAR_ERR = 1'b0;
        bus.WR_FRM_ERR = 1'b0; bus.RD_EN = 1'b0; bus.OVR_CLR = 1'b0;
        rst = 1'b0;
        m_ovr = 1'b0; m_rv = 1'b0; m_rd = 8'h00; m_pe = 1'b0; m_fe = 1'b0; m_err = 0;

        // Reset state
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset empty", 32'(bus.EMPTY), 32'd1);
        chk("reset level", 32'(bus.LEVEL), 32'd0);
        chk("reset full", 32'(bus.FULL), 32'd0);
        chk("reset overrun", 32'(bus.OVERRUN), 32'd0);
        chk("reset rd_valid", 32'(bus.RD_VALID), 32'd0);
        chk("reset rd_data", 32'(bus.RD_DATA), 32'd0);
        idle();

        // Basic order, empty-read and parity-flag vectors
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].wv, tbl[i].wd, tbl[i].pe, 1'b0, tbl[i].re, 1'b0, 1'b1);
            chk($sformatf("vec%0d rd_valid", i), 32'(bus.RD_VALID), 32'(tbl[i].e_rv));
            chk($sformatf("vec%0d rd_data", i), 32'(bus.RD_DATA), 32'(tbl[i].e_rd));
            chk($sformatf("vec%0d rd_par", i), 32'(bus.RD_PAR_ERR), 32'(tbl[i].e_pe));
            chk($sformatf("vec%0d empty", i), 32'(bus.EMPTY), 32'(tbl[i].e_empty));
            chk($sformatf("vec%0d level", i), 32'(bus.LEVEL), 32'(tbl[i].e_lvl));
        end
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk("err_count after errored frame", 32'(bus.ERR_COUNT), 32'd1);
`endif

        // Fill, overflow drop, and set-wins-over-clear
        for (int i = 0; i < 16; i++) begin
            wr(8'(i));
            check_model($sformatf("fill%0d", i));
        end
        wr(8'hAA);
        chk("ovf full", 32'(bus.FULL), 32'd1);
        chk("ovf overrun", 32'(bus.OVERRUN), 32'd1);
        chk("ovf level", 32'(bus.LEVEL), 32'd16);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("set wins overrun", 32'(bus.OVERRUN), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd();
            check_model($sformatf("drain%0d", i));
            chk($sformatf("drain%0d data", i), 32'(bus.RD_DATA), 32'(i));
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovr_clr overrun", 32'(bus.OVERRUN), 32'd0);
        check_model("after clr");

        // Simultaneous read+write while full
        for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rw full rd_data", 32'(bus.RD_DATA), 32'h80);
        chk("rw full level", 32'(bus.LEVEL), 32'd16);
        chk("rw full overrun", 32'(bus.OVERRUN), 32'd0);
        check_model("rw full");
        for (int i = 0; i < 16; i++) begin
            rd();
            check_model($sformatf("rwdrain%0d", i));
        end
        chk("rw last entry", 32'(bus.RD_DATA), 32'h5A);

        // Simultaneous read+write while empty: write kept, read ignored
        cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rw empty rd_valid", 32'(bus.RD_VALID), 32'd0);
        chk("rw empty level", 32'(bus.LEVEL), 32'd1);
        rd();
        chk("rw empty data", 32'(bus.RD_DATA), 32'hC3);

        // Framing error flag travels with its frame
        cycle(1'b1, 8'h3F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        rd();
        check_model("frm flag");

        // Pointer wrap with write/read pairs
        rd();
        chk("empty read rd_valid", 32'(bus.RD_VALID), 32'd0);
        check_model("empty read");
        for (int i = 0; i < 40; i++) begin
            wr(8'((i * 7 + 3) & 8'hFF));
            check_model($sformatf("wrap w%0d", i));
            rd();
            check_model($sformatf("wrap r%0d", i));
            chk($sformatf("wrap r%0d data", i), 32'(bus.RD_DATA), 32'((i * 7 + 3) & 255));
        end
        chk("wrap level", 32'(bus.LEVEL), 32'd0);

        // Reset mid-operation discards stored frames
        for (int i = 0; i < 5; i++) wr(8'(8'hE0 + i));
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst empty", 32'(bus.EMPTY), 32'd1);
        chk("midrst level", 32'(bus.LEVEL), 32'd0);
        chk("midrst overrun", 32'(bus.OVERRUN), 32'd0);
        chk("midrst rd_valid", 32'(bus.RD_VALID), 32'd0);
        check_model("midrst");
        wr(8'h3C);
        rd();
        chk("post rst rd_valid", 32'(bus.RD_VALID), 32'd1);
        chk("post rst data", 32'(bus.RD_DATA), 32'h3C);
        check_model("post rst");
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
